// File: rtl/eq_pkg.sv
// Shared constants and state encoding for the equalizer output capture sink.
package eq_pkg;

    localparam int EQ_SAMPLE_W    = 16;
    localparam int EQ_SUM_W       = 32;
    localparam int EQ_CAP_DEPTH   = 32062;
    localparam int EQ_CAP_ADDR_W  = 15;

    typedef enum logic [2:0] {
        IDLE,
        SKIP,
        CAPTURE,
        DONE,
        DRAIN
    } eq_cap_state_t;

    // A zero or oversized capture length means "fill the whole RAM".
    function automatic int unsigned eq_cap_target(input int unsigned len,
                                                  input int unsigned depth);
        return (len == 0 || len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/eq_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// The array is deliberately not reset so it maps onto block RAM.
module eq_capture_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32062,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write on we, read with one cycle of latency on re.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/eq_sample_capture.sv
// Capture sink for the summed equalizer output: skip fill latency, store a
// window of samples, then replay them over a valid/ready port.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | nothing captured, waiting for start
//  SKIP    | discarding leading samples until skip count runs out
//  CAPTURE | writing samples to RAM from address 0
//  DONE    | capture complete, stored count held, start/dump accepted
//  DRAIN   | replaying stored samples from address 0
module eq_sample_capture
    import eq_pkg::*;
#(
    parameter int DATA_W = EQ_SUM_W,
    parameter int DEPTH  = EQ_CAP_DEPTH,
    parameter int ADDR_W = EQ_CAP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] skip_len,
    input  logic [ADDR_W-1:0] cap_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              dump,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    eq_cap_state_t state_q, state_d;

    logic [ADDR_W-1:0] skip_cnt_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W-1:0] cap_tgt_q;
    logic [ADDR_W-1:0] rd_addr_q;

    logic              pend_q;
    logic              pend_last_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_last_q;

    logic              start_ok;
    logic              dump_ok;
    logic              cap_we;
    logic              fire;
    logic [1:0]        occ_after;
    logic              reads_left;
    logic              rd_issue;
    logic [ADDR_W-1:0] ram_raddr;
    logic              issue_last;
    logic [DATA_W-1:0] ram_q;

    // Qualified control pulses; abort beats start, start beats dump in DONE.
    always_comb begin
        start_ok   = start && !abort && (state_q == IDLE || state_q == DONE);
        dump_ok    = dump && !abort && !start && (state_q == DONE);
        cap_we     = in_valid && !abort && (state_q == CAPTURE);
        fire       = out_valid_q && rd_ready;
        // Entries held after this edge: out + skid + in-flight RAM read, minus a transfer.
        occ_after  = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(pend_q) - 2'(fire);
        reads_left = (state_q == DRAIN) && (rd_addr_q != wr_ptr_q);
        // The first read goes out on the dump cycle itself to hit two-cycle latency.
        rd_issue   = dump_ok || (!abort && reads_left && occ_after < 2'd2);
        ram_raddr  = dump_ok ? '0 : rd_addr_q;
        issue_last = (ram_raddr == wr_ptr_q - ONE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) state_d = (skip_len != '0) ? SKIP : CAPTURE;
                end
                SKIP: begin
                    if (in_valid && skip_cnt_q == ONE) state_d = CAPTURE;
                end
                CAPTURE: begin
                    if (in_valid && (wr_ptr_q + ONE) == cap_tgt_q) state_d = DONE;
                end
                DONE: begin
                    if (start_ok)     state_d = (skip_len != '0) ? SKIP : CAPTURE;
                    else if (dump_ok) state_d = DRAIN;
                end
                DRAIN: begin
                    if (fire && out_last_q) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Skip down-counter, write pointer / stored count, and replay address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt_q <= '0;
            wr_ptr_q   <= '0;
            cap_tgt_q  <= '0;
            rd_addr_q  <= '0;
        end else if (abort) begin
            skip_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_addr_q  <= '0;
        end else if (start_ok) begin
            skip_cnt_q <= skip_len;
            cap_tgt_q  <= ADDR_W'(eq_cap_target(32'(cap_len), 32'(DEPTH)));
            wr_ptr_q   <= '0;
            rd_addr_q  <= '0;
        end else begin
            if (state_q == SKIP && in_valid) begin
                skip_cnt_q <= skip_cnt_q - ONE;
            end
            if (cap_we) begin
                wr_ptr_q <= wr_ptr_q + ONE;
            end
            if (dump_ok) begin
                rd_addr_q <= ONE;
            end else if (rd_issue) begin
                rd_addr_q <= rd_addr_q + ONE;
            end
        end
    end

    // Read pipeline: in-flight RAM read, output register and one-entry skid
    // register so a stalled consumer never loses the read already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
        end else if (abort) begin
            pend_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            pend_q      <= rd_issue;
            pend_last_q <= issue_last;
            if (!out_valid_q || fire) begin
                if (skid_valid_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= skid_data_q;
                    out_last_q   <= skid_last_q;
                    skid_valid_q <= pend_q;
                    skid_data_q  <= ram_q;
                    skid_last_q  <= pend_last_q;
                end else if (pend_q) begin
                    out_valid_q  <= 1'b1;
                    out_data_q   <= ram_q;
                    out_last_q   <= pend_last_q;
                end else begin
                    out_valid_q  <= 1'b0;
                    out_last_q   <= 1'b0;
                end
            end else if (pend_q) begin
                skid_valid_q <= 1'b1;
                skid_data_q  <= ram_q;
                skid_last_q  <= pend_last_q;
            end
        end
    end

    eq_capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (cap_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .re    (rd_issue),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // Status outputs decoded from registered state.
    always_comb begin
        rd_valid = out_valid_q;
        rd_data  = out_data_q;
        rd_last  = out_last_q;
        busy     = (state_q == SKIP) || (state_q == CAPTURE) || (state_q == DRAIN);
        done     = (state_q == DONE);
    end

endmodule

// File: tb/tb_eq_sample_capture.sv
// Scoreboard bench for eq_sample_capture: stimulus pushes expected replay
// samples, a negedge monitor pops and compares on every accepted transfer.
module tb_eq_sample_capture;
    import eq_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 100;
    localparam int AW    = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] skip_len = '0;
    logic [AW-1:0] cap_len = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          dump = 1'b0;
    logic          rd_ready = 1'b0;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_last;
    logic          busy;
    logic          done;

    eq_sample_capture #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .skip_len (skip_len),
        .cap_len  (cap_len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .dump     (dump),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .rd_last  (rd_last),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail = 0;

    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each accepted transfer and verify stall stability.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(rd_valid), 64'd1);
                chk("stall_data", 64'(rd_data), 64'(prev_data));
                chk("stall_last", 64'(rd_last), 64'(prev_last));
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_transfer: got data %0h, want no transfer", rd_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(mon_e.data));
                    chk("rd_last", 64'(rd_last), 64'(mon_e.last));
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            prev_last  = rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse; length inputs are scrambled afterwards to prove they were latched.
    task automatic arm(input int sk, input int cl);
        start    = 1'b1;
        skip_len = AW'(sk);
        cap_len  = AW'(cl);
        tick();
        start    = 1'b0;
        skip_len = '1;
        cap_len  = 15'd3;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic v);
        in_valid = v;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l);
        exp_q.push_back('{data: d, last: l});
    endtask

    task automatic pulse_dump();
        dump = 1'b1;
        tick();
        dump = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input int ready_pct);
        int i;
        for (i = 0; i < budget; i++) begin
            if (exp_q.size() == 0 && done) break;
            rd_ready = ($urandom_range(0, 99) < ready_pct);
            tick();
        end
        rd_ready = 1'b0;
        if (i == budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d samples left, want 0 within %0d cycles", exp_q.size(), budget);
            exp_q.delete();
        end
        chk("drain_done", 64'(done), 64'd1);
        chk("drain_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] v2 [3];
        v2[0] = 32'hFFFF_FFFB;   // -5
        v2[1] = 32'h0000_0007;   //  7
        v2[2] = 32'hFFFF_8000;   // -32768

        // Reset values
        #12;
        chk("rst_valid", 64'(rd_valid), 64'd0);
        chk("rst_busy",  64'(busy),     64'd0);
        chk("rst_done",  64'(done),     64'd0);
        chk("rst_data",  64'(rd_data),  64'd0);
        chk("rst_last",  64'(rd_last),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Test 1: skip 62, capture 4 of a ramp
        arm(62, 4);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 100; i++) begin
            send(DW'(i), 1'b1);
            if (i == 64) chk("t1_done_early", 64'(done), 64'd0);
            if (i == 65) chk("t1_done", 64'(done), 64'd1);
        end
        for (int i = 62; i < 66; i++) push(DW'(i), i == 65);
        rd_ready = 1'b1;
        pulse_dump();
        chk("t1_lat1", 64'(rd_valid), 64'd0);
        tick();
        chk("t1_lat2", 64'(rd_valid), 64'd1);
        wait_drain(200, 100);

        // Test 2: no skip, sparse valid, signed values
        arm(0, 3);
        for (int k = 0; k < 6; k++) begin
            send((k % 2 == 0) ? v2[k / 2] : 32'd123, k % 2 == 0);
        end
        chk("t2_done", 64'(done), 64'd1);
        for (int k = 0; k < 3; k++) push(v2[k], k == 2);
        rd_ready = 1'b1;
        pulse_dump();
        wait_drain(200, 100);

        // Test 3: 8 samples replayed against a 30% ready consumer
        arm(0, 8);
        for (int k = 0; k < 8; k++) send(32'h8000_0000 + DW'(k * 77), 1'b1);
        chk("t3_done", 64'(done), 64'd1);
        for (int k = 0; k < 8; k++) push(32'h8000_0000 + DW'(k * 77), k == 7);
        pulse_dump();
        wait_drain(2000, 30);

        // Test 4: cap_len=0 fills DEPTH, then cap_len>DEPTH also fills DEPTH
        arm(0, 0);
        for (int i = 0; i < 150; i++) begin
            send(DW'(1000 + i), 1'b1);
            if (i == DEPTH - 2) chk("t4_done_early", 64'(done), 64'd0);
            if (i == DEPTH - 1) chk("t4_done", 64'(done), 64'd1);
        end
        for (int i = 0; i < DEPTH; i++) push(DW'(1000 + i), i == DEPTH - 1);
        pulse_dump();
        wait_drain(1000, 100);
        arm(0, 120);
        for (int i = 0; i < DEPTH; i++) begin
            send(DW'(i), 1'b1);
            if (i == DEPTH - 2) chk("t4b_done_early", 64'(done), 64'd0);
        end
        chk("t4b_done", 64'(done), 64'd1);

        // Test 5: abort mid-capture, then start+abort together in DONE
        arm(0, 10);
        for (int k = 0; k < 3; k++) send(DW'(k), 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_done", 64'(done), 64'd0);
        arm(0, 2);
        send(32'hA5A5_0001, 1'b1);
        send(32'h5A5A_0002, 1'b1);
        chk("t5_done", 64'(done), 64'd1);
        push(32'hA5A5_0001, 1'b0);
        push(32'h5A5A_0002, 1'b1);
        pulse_dump();
        wait_drain(200, 100);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("t5_sa_done", 64'(done), 64'd0);
        chk("t5_sa_busy", 64'(busy), 64'd0);
        rd_ready = 1'b1;
        pulse_dump();
        tick();
        chk("t5_dump_ignored", 64'(rd_valid), 64'd0);
        rd_ready = 1'b0;

        // Test 6: asynchronous reset while a replay is stalled
        arm(0, 5);
        for (int k = 0; k < 5; k++) send(DW'(k + 40), 1'b1);
        pulse_dump();
        tick();
        chk("t6_valid", 64'(rd_valid), 64'd1);
        chk("t6_busy",  64'(busy),     64'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(rd_valid), 64'd0);
        chk("t6_rst_busy",  64'(busy),     64'd0);
        chk("t6_rst_done",  64'(done),     64'd0);
        chk("t6_rst_data",  64'(rd_data),  64'd0);
        exp_q.delete();
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_idle_busy", 64'(busy), 64'd0);
        chk("t6_idle_done", 64'(done), 64'd0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
